ce_reg_rr_arbiter: RTL and testbench
====================================

Name: ce_reg_rr_arbiter

Overview:
- Shares one clock-enabled register (WIDTH bits, mux-fed CE) between N requesters using round-robin arbitration.
- Each requester presents data under a valid/ready handshake. The arbiter drives the register's CE and data, and records which requester wrote last.
- Sits between multiple producers and a single shared state/config register in the datapath.

Parameters:
N, 4, number of requesters (2..16; need not be a power of two)
WIDTH, 8, register data width
INIT, 0, register reset/initial value (WIDTH bits)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  synchronous, active-high reset
req_valid  input  N  bit i: requester i has data
req_data  input  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
req_ready  output  N  one-hot grant; transfer when req_valid[i] & req_ready[i]
O  output  WIDTH  shared register value
owner  output  clog2(N) (min 1)  index of requester whose data is in O
update  output  1  high for one cycle when O was loaded on the previous edge
lock  input  N  burst lock request (present only with ARB_LOCK_EN)

Behaviour:
- Interface: one clock CLK; reset RESET is synchronous and active-high.
- Reset state (edge with RESET=1): O=INIT, owner=0, update=0, ptr=0, lock FSM=UNLOCKED.
- While RESET=1: req_ready=0 and no write occurs.
- ptr: internal round-robin pointer, clog2(N) bits. Requester ptr has highest priority, then ptr+1 … ptr+N-1, all mod N.
- Grant is combinational on the same cycle: g = first i in priority order with req_valid[i]=1.
  - req_ready[g]=1; all other bits 0.
  - If no requester is valid, req_ready=0.
- Write on a transfer: CE=1 and the register loads req_data[g] on the next edge. Latency is 1: O shows the new value the cycle after the transfer.
  - owner<=g, update<=1, ptr<=(g+1) mod N.
  - Wrap: g=N-1 gives ptr=0. For N not a power of two, ptr never takes values ≥N.
- No transfer: CE=0; O, owner and ptr hold; update<=0.
- Multiple valids on one cycle: exactly one is granted. Losers get ready=0 and must keep valid and data stable until granted.
- Fairness: a continuously valid requester is granted within N cycles.
- Changes to req_data of a non-granted requester have no effect.
- RESET asserted mid-stream: any same-cycle transfer is dropped (ready=0) and state returns to reset values on that edge.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: lock port exists; two-state FSM UNLOCKED / LOCKED(L).
  - UNLOCKED: grants as above. A transfer by g with lock[g]=1 moves the FSM to LOCKED with L=g; ptr does not advance.
  - LOCKED: req_ready = req_valid[L] on bit L only; all other requesters are blocked. Transfers load O as normal and ptr stays unchanged.
  - Exit to UNLOCKED on any cycle where lock[L]=0. If that cycle also carries a transfer from L, the write completes and ptr<=(L+1) mod N.
  - RESET forces UNLOCKED.
- Undefined: no lock port and no FSM; pure round-robin.

Test Plan:
- Reset: hold RESET 2 cycles with req_valid=4'b1111 -> req_ready=0, O=0x00, owner=0, update=0; after release, first grant is req 0.
- Single requester: req_valid=4'b0100, data2=0x5A for 1 cycle -> req_ready=4'b0100 that cycle; next cycle O=0x5A, owner=2, update=1; following cycle update=0, O holds.
- Round robin: req_valid=4'b1111 held for 8 cycles, data_i=0x10+i -> grant order 0,1,2,3,0,1,2,3; O sequence 0x10,0x11,0x12,0x13,… one cycle later; ptr wraps 3->0.
- Skip and priority: ptr=1, req_valid=4'b1001 -> grant 3, then ptr=0, grant 0; req 1 and req 2 are never granted.
- Idle hold and mid-stream reset: valid drops to 0 -> O/owner hold, update=0. RESET pulsed while req_valid=4'b0010 -> no write; O=INIT next cycle.
- ARB_LOCK_EN: req 1 transfers with lock[1]=1 while req_valid=4'b1111 for 3 cycles -> only req 1 is granted (O=0x11 each write). Drop lock[1] on the last transfer -> next grant is req 2.

Source files
------------

// File: rtl/ce_reg_rr_arbiter.sv
// Round-robin arbiter sharing one clock-enabled WIDTH-bit register between N requesters.
// Define ARB_LOCK_EN to add the lock port and the burst-lock FSM.
module ce_reg_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT = '0,
    localparam int unsigned OW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    output logic [WIDTH-1:0]     O,
    output logic [OW-1:0]        owner,
    output logic                 update
);

    typedef logic [OW-1:0] idx_t;

    function automatic idx_t wrap_inc(input idx_t i);
        return (32'(i) == N - 1) ? '0 : i + OW'(1);
    endfunction

    logic [WIDTH-1:0] data_arr [N];
    idx_t             ptr_q, ptr_d;
    idx_t             gnt_idx;
    logic             gnt_found;
    logic             xfer;
    logic [WIDTH-1:0] o_d;
    idx_t             owner_d;
    logic             update_d;

`ifdef ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;
    state_t state_q, state_d;
    idx_t   lock_idx_q, lock_idx_d;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Grant search, register next value and pointer/lock next state.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        req_ready = '0;
        o_d       = O;
        owner_d   = owner;
        ptr_d     = ptr_q;
`ifdef ARB_LOCK_EN
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
`endif

        for (int k = 0; k < N; k++) begin
            logic [OW:0] sum;
            sum = {1'b0, ptr_q} + (OW+1)'(k);
            if (sum >= (OW+1)'(N)) sum = sum - (OW+1)'(N);
            if (!gnt_found && req_valid[sum[OW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[OW-1:0];
            end
        end

`ifdef ARB_LOCK_EN
        // A locked burst owner masks everyone else.
        if (state_q == LOCKED) begin
            gnt_found = req_valid[lock_idx_q];
            gnt_idx   = lock_idx_q;
        end
`endif

        xfer = gnt_found && !RESET;
        if (xfer) req_ready[gnt_idx] = 1'b1;
        update_d = xfer;

        if (xfer) begin
            o_d     = data_arr[gnt_idx];
            owner_d = gnt_idx;
            ptr_d   = wrap_inc(gnt_idx);
        end

`ifdef ARB_LOCK_EN
        case (state_q)
            UNLOCKED: begin
                if (xfer && lock[gnt_idx]) begin
                    state_d    = LOCKED;
                    lock_idx_d = gnt_idx;
                    ptr_d      = ptr_q;
                end
            end
            LOCKED: begin
                ptr_d = ptr_q;
                if (!lock[lock_idx_q]) begin
                    state_d = UNLOCKED;
                    if (xfer) ptr_d = wrap_inc(lock_idx_q);
                end
            end
            default: state_d = UNLOCKED;
        endcase
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            O      <= INIT;
            owner  <= '0;
            update <= 1'b0;
            ptr_q  <= '0;
`ifdef ARB_LOCK_EN
            state_q    <= UNLOCKED;
            lock_idx_q <= '0;
`endif
        end else begin
            O      <= o_d;
            owner  <= owner_d;
            update <= update_d;
            ptr_q  <= ptr_d;
`ifdef ARB_LOCK_EN
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_ce_reg_rr_arbiter.sv
// Directed plus randomized bench for ce_reg_rr_arbiter against an arithmetic round-robin model.
module tb_ce_reg_rr_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] INIT = 8'h00;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RESET;
    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       lock;
    logic [WIDTH-1:0]   O;
    logic [1:0]         owner;
    logic               update;

    ce_reg_rr_arbiter #(.N(N), .WIDTH(WIDTH), .INIT(INIT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .O(O),
        .owner(owner),
        .update(update)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    int m_ptr = 0, m_owner = 0, m_upd = 0, m_L = 0;
    int m_o = 0;
    bit m_locked = 1'b0;
    int last_g = -1;

    function automatic int model_grant();
        if (m_locked) return req_valid[m_L] ? m_L : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] v,
                         input logic [N*WIDTH-1:0] d, input logic [N-1:0] lk);
        int g;
        bit was_locked;
        logic [N-1:0] exp_ready;
        @(negedge CLK);
        RESET = rst; req_valid = v; req_data = d; lock = lk;
        #1;
        g = rst ? -1 : model_grant();
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (rst) begin
            m_ptr = 0; m_o = int'(INIT); m_owner = 0; m_upd = 0; m_locked = 0; m_L = 0;
        end else begin
            was_locked = m_locked;
            if (g >= 0) begin
                m_o = int'(d[g*WIDTH +: WIDTH]); m_owner = g; m_upd = 1;
            end else m_upd = 0;
            if (!was_locked) begin
                if (g >= 0) begin
                    if (LOCK_EN && lk[g]) begin m_locked = 1; m_L = g; end
                    else m_ptr = (g + 1) % N;
                end
            end else if (!lk[m_L]) begin
                m_locked = 0;
                if (g >= 0) m_ptr = (m_L + 1) % N;
            end
        end
        @(posedge CLK); #1;
        check("O", 32'(O), 32'(m_o));
        check("owner", 32'(owner), 32'(m_owner));
        check("update", 32'(update), 32'(m_upd));
        last_g = g;
    endtask

    initial begin
        logic [N*WIDTH-1:0] d_rr;
        logic [N*WIDTH-1:0] d_s;
        logic [N-1:0]       cv;
        logic [N*WIDTH-1:0] cd;
        logic [N-1:0]       clk_lock;
        logic               rst;
        d_rr = {8'h13, 8'h12, 8'h11, 8'h10};
        d_s  = {8'h00, 8'h5A, 8'h00, 8'h00};
        RESET = 1'b1; req_valid = '0; req_data = '0; lock = '0;

        // Reset held with all requesters valid
        cycle(1'b1, 4'b1111, d_rr, 4'b0000);
        cycle(1'b1, 4'b1111, d_rr, 4'b0000);
        check("reset_O", 32'(O), 32'(INIT));
        // Round robin, first grant is req 0, wraps 3->0
        for (int c = 0; c < 8; c++) cycle(1'b0, 4'b1111, d_rr, 4'b0000);
        // Idle hold
        cycle(1'b0, 4'b0000, d_rr, 4'b0000);
        cycle(1'b0, 4'b0000, d_rr, 4'b0000);
        // Single requester 2
        cycle(1'b0, 4'b0100, d_s, 4'b0000);
        cycle(1'b0, 4'b0000, d_s, 4'b0000);
        check("single_O_hold", 32'(O), 32'h5A);
        // Skip and priority from ptr=1
        cycle(1'b0, 4'b0001, d_rr, 4'b0000);
        cycle(1'b0, 4'b1001, d_rr, 4'b0000);
        cycle(1'b0, 4'b1001, d_rr, 4'b0000);
        // Mid-stream reset drops the transfer
        cycle(1'b1, 4'b0010, d_rr, 4'b0000);
        check("midreset_O", 32'(O), 32'(INIT));
        cycle(1'b0, 4'b0000, d_rr, 4'b0000);
        // Burst lock by req 1, released on its last transfer
        cycle(1'b0, 4'b0001, d_rr, 4'b0000);
        cycle(1'b0, 4'b1111, d_rr, 4'b0010);
        cycle(1'b0, 4'b1111, d_rr, 4'b0010);
        cycle(1'b0, 4'b1111, d_rr, 4'b0000);
        cycle(1'b0, 4'b1111, d_rr, 4'b0000);

        // Random traffic; losers hold valid and data until granted
        cv = '0; cd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cv[i] && i != last_g)) begin
                    cv[i] = ($urandom_range(0, 3) != 0);
                    cd[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
                clk_lock[i] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle(rst, cv, cd, clk_lock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
